// File: rtl/biss_c_frame_rx.sv
// BiSS-C master frame engine: drives MA, samples SLO, splits the single-cycle
// frame into fields and feeds the CRC-covered bits to the external CRC unit.
module biss_c_frame_rx #(
   parameter int CLK_DIV        = 25,
   parameter int DATA_BITS      = 26,
   parameter int TIMEOUT_CYCLES = 4000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 SLO,
   output logic                 MA,
   output logic                 CRC_CLEAR,
   output logic                 BIT_VAL,
   output logic                 BIT_STRB,
   input  logic [5:0]           CRC_IN,
   output logic [DATA_BITS-1:0] POS_DATA,
   output logic                 ERR_N,
   output logic                 WARN_N,
   output logic                 CRC_OK,
   output logic                 DATA_VALID,
   output logic                 TIMEOUT_ERR,
   output logic                 BUSY
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_WAIT_ACK   = 4'd1;
   localparam logic [3:0] S_WAIT_START = 4'd2;
   localparam logic [3:0] S_CDS        = 4'd3;
   localparam logic [3:0] S_DATA       = 4'd4;
   localparam logic [3:0] S_ERRW       = 4'd5;
   localparam logic [3:0] S_CRC        = 4'd6;
   localparam logic [3:0] S_CHECK      = 4'd7;
   localparam logic [3:0] S_WAIT_IDLE  = 4'd8;

   logic [3:0]           state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 ma_q, ma_d;
   logic                 ma_run_q, ma_run_d;
   logic                 slo_s1_q, slo_sync_q;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [WD_W-1:0]      wdog_q, wdog_d;
   logic [DATA_BITS-1:0] pos_sh_q, pos_sh_d;
   logic [1:0]           errw_sh_q, errw_sh_d;
   logic [5:0]           crc_rx_q, crc_rx_d;
   logic                 busy_q, busy_d;
   logic                 crc_clear_q, crc_clear_d;
   logic                 bit_val_q, bit_val_d;
   logic                 bit_strb_q, bit_strb_d;
   logic [DATA_BITS-1:0] pos_data_q, pos_data_d;
   logic                 err_n_q, err_n_d;
   logic                 warn_n_q, warn_n_d;
   logic                 crc_ok_q, crc_ok_d;
   logic                 data_valid_q, data_valid_d;
   logic                 timeout_err_q, timeout_err_d;

   logic div_last, sample_tick, wd_hit;

   assign div_last    = (div_q == DIV_W'(CLK_DIV - 1));
   // Sampling happens on the MA low->high transition, the edge the slave's data is valid for.
   assign sample_tick = ma_run_q && !ma_q && div_last;
   assign wd_hit      = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d       = state_q;
      div_d         = div_q;
      ma_d          = ma_q;
      ma_run_d      = ma_run_q;
      bit_cnt_d     = bit_cnt_q;
      pos_sh_d      = pos_sh_q;
      errw_sh_d     = errw_sh_q;
      crc_rx_d      = crc_rx_q;
      busy_d        = busy_q;
      crc_clear_d   = 1'b0;
      bit_val_d     = bit_val_q;
      bit_strb_d    = 1'b0;
      pos_data_d    = pos_data_q;
      err_n_d       = err_n_q;
      warn_n_d      = warn_n_q;
      crc_ok_d      = crc_ok_q;
      data_valid_d  = 1'b0;
      timeout_err_d = 1'b0;

      if (ma_run_q) begin
         if (div_last) begin
            div_d = '0;
            ma_d  = ~ma_q;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end

      wdog_d = '0;
      if (state_q == S_WAIT_ACK || state_q == S_WAIT_START || state_q == S_WAIT_IDLE)
         wdog_d = wdog_q + WD_W'(1);

      case (state_q)
         S_IDLE: begin
            if (START) begin
               crc_clear_d = 1'b1;
               busy_d      = 1'b1;
               ma_run_d    = 1'b1;
               ma_d        = 1'b1;
               div_d       = '0;
               state_d     = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK, S_WAIT_START: begin
            if (wd_hit) begin
               timeout_err_d = 1'b1;
               ma_run_d      = 1'b0;
               ma_d          = 1'b1;
               div_d         = '0;
               wdog_d        = '0;
               state_d       = S_WAIT_IDLE;
            end else if (sample_tick) begin
               if (state_q == S_WAIT_ACK && !slo_sync_q)
                  state_d = S_WAIT_START;
               else if (state_q == S_WAIT_START && slo_sync_q)
                  state_d = S_CDS;
            end
         end
         S_CDS: begin
            if (sample_tick) begin
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (sample_tick) begin
               pos_sh_d   = {pos_sh_q[DATA_BITS-2:0], slo_sync_q};
               bit_val_d  = slo_sync_q;
               bit_strb_d = 1'b1;
               if (bit_cnt_q == 6'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = S_ERRW;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         S_ERRW: begin
            if (sample_tick) begin
               errw_sh_d  = {errw_sh_q[0], slo_sync_q};
               bit_val_d  = slo_sync_q;
               bit_strb_d = 1'b1;
               if (bit_cnt_q == 6'd1) begin
                  bit_cnt_d = '0;
                  state_d   = S_CRC;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         S_CRC: begin
            if (sample_tick) begin
               crc_rx_d = {crc_rx_q[4:0], slo_sync_q};
               if (bit_cnt_q == 6'd5) begin
                  // Last bit: MA is rising on this edge anyway; park it high.
                  ma_run_d  = 1'b0;
                  ma_d      = 1'b1;
                  div_d     = '0;
                  bit_cnt_d = '0;
                  state_d   = S_CHECK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         S_CHECK: begin
            // The settle cycles give the CRC unit time to absorb the final strobe.
            if (bit_cnt_q == 6'd2) begin
               pos_data_d   = pos_sh_q;
               err_n_d      = errw_sh_q[1];
               warn_n_d     = errw_sh_q[0];
               crc_ok_d     = (CRC_IN == ~crc_rx_q);
               data_valid_d = 1'b1;
               bit_cnt_d    = '0;
               state_d      = S_WAIT_IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + 6'd1;
            end
         end
         S_WAIT_IDLE: begin
            if (slo_sync_q) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (wd_hit) begin
               timeout_err_d = 1'b1;
               busy_d        = 1'b0;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         div_q         <= '0;
         ma_q          <= 1'b1;
         ma_run_q      <= 1'b0;
         // Synchroniser starts at the idle line level.
         slo_s1_q      <= 1'b1;
         slo_sync_q    <= 1'b1;
         bit_cnt_q     <= '0;
         wdog_q        <= '0;
         pos_sh_q      <= '0;
         errw_sh_q     <= '0;
         crc_rx_q      <= '0;
         busy_q        <= 1'b0;
         crc_clear_q   <= 1'b0;
         bit_val_q     <= 1'b0;
         bit_strb_q    <= 1'b0;
         pos_data_q    <= '0;
         err_n_q       <= 1'b0;
         warn_n_q      <= 1'b0;
         crc_ok_q      <= 1'b0;
         data_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         ma_q          <= ma_d;
         ma_run_q      <= ma_run_d;
         slo_s1_q      <= SLO;
         slo_sync_q    <= slo_s1_q;
         bit_cnt_q     <= bit_cnt_d;
         wdog_q        <= wdog_d;
         pos_sh_q      <= pos_sh_d;
         errw_sh_q     <= errw_sh_d;
         crc_rx_q      <= crc_rx_d;
         busy_q        <= busy_d;
         crc_clear_q   <= crc_clear_d;
         bit_val_q     <= bit_val_d;
         bit_strb_q    <= bit_strb_d;
         pos_data_q    <= pos_data_d;
         err_n_q       <= err_n_d;
         warn_n_q      <= warn_n_d;
         crc_ok_q      <= crc_ok_d;
         data_valid_q  <= data_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign MA          = ma_q;
   assign CRC_CLEAR   = crc_clear_q;
   assign BIT_VAL     = bit_val_q;
   assign BIT_STRB    = bit_strb_q;
   assign POS_DATA    = pos_data_q;
   assign ERR_N       = err_n_q;
   assign WARN_N      = warn_n_q;
   assign CRC_OK      = crc_ok_q;
   assign DATA_VALID  = data_valid_q;
   assign TIMEOUT_ERR = timeout_err_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_biss_c_frame_rx.sv
// Directed bench for biss_c_frame_rx: behavioural BiSS-C slave, reference CRC
// unit on the strobe interface, and per-scenario checks of fields and timing.
module tb_biss_c_frame_rx;

   localparam int DB = 26;

   logic          CLK = 1'b0;
   logic          RST, START, SLO;
   logic          MA, CRC_CLEAR, BIT_VAL, BIT_STRB;
   logic [5:0]    CRC_IN;
   logic [DB-1:0] POS_DATA;
   logic          ERR_N, WARN_N, CRC_OK, DATA_VALID, TIMEOUT_ERR, BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   biss_c_frame_rx #(.CLK_DIV(25), .DATA_BITS(DB), .TIMEOUT_CYCLES(4000)) dut (
      .CLK(CLK), .RST(RST), .START(START), .SLO(SLO), .MA(MA),
      .CRC_CLEAR(CRC_CLEAR), .BIT_VAL(BIT_VAL), .BIT_STRB(BIT_STRB), .CRC_IN(CRC_IN),
      .POS_DATA(POS_DATA), .ERR_N(ERR_N), .WARN_N(WARN_N), .CRC_OK(CRC_OK),
      .DATA_VALID(DATA_VALID), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   function automatic logic [5:0] crc_step(input logic [5:0] c, input logic b);
      logic fb;
      fb = c[5] ^ b;
      return {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
   endfunction

   function automatic logic [5:0] crc6(input logic [63:0] b, input int n);
      logic [5:0] c;
      c = 6'h00;
      for (int i = n - 1; i >= 0; i--) c = crc_step(c, b[i]);
      return c;
   endfunction

   // Downstream CRC unit stand-in.
   logic [5:0] crc_m;
   always @(posedge CLK) begin
      if (RST || CRC_CLEAR) crc_m <= 6'h00;
      else if (BIT_STRB)    crc_m <= crc_step(crc_m, BIT_VAL);
   end
   assign CRC_IN = crc_m;

   // Line order: idle 1, Ack 0, Start 1, CDS 0, data, nE, nW, CRC.
   function automatic logic [63:0] mk_frame(input logic [31:0] d, input logic ne, input logic nw,
                                            input logic [5:0] crcl);
      return {26'd0, 4'b1010, d[25:0], ne, nw, crcl};
   endfunction

   int            r_strb, r_dv, r_clr, r_clr_at, r_tmo, r_tmo_at, r_ma_low_post;
   int            r_fall1, r_rise1, r_fall2, r_rel_at, r_busy_fall_at;
   logic [63:0]   r_strb_bits;
   logic [DB-1:0] r_pos;
   logic          r_err, r_warn, r_ok;
   logic [5:0]    r_crc_in;

   task automatic run_frame(input logic [63:0] bits, input int len, input int rst_at,
                            input bit start_mid);
      int   idx, tmo_cnt;
      bit   tmo_on;
      logic ma_prev;
      r_strb = 0; r_dv = 0; r_clr = 0; r_clr_at = -1; r_tmo = 0; r_tmo_at = -1;
      r_ma_low_post = 0; r_fall1 = -1; r_rise1 = -1; r_fall2 = -1; r_rel_at = -1;
      r_busy_fall_at = -1; r_strb_bits = '0; r_pos = '0; r_err = 0; r_warn = 0; r_ok = 0;
      r_crc_in = '0;
      idx = 0; tmo_cnt = 0; tmo_on = 0; ma_prev = 1'b1;
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      for (int n = 0; n < 12000; n++) begin
         if (n > 0) @(negedge CLK);
         START = start_mid && (n == 300);
         if (CRC_CLEAR) begin r_clr++; r_clr_at = n; end
         if (BIT_STRB) begin r_strb++; r_strb_bits = {r_strb_bits[62:0], BIT_VAL}; end
         if (DATA_VALID) begin
            r_dv++; r_pos = POS_DATA; r_err = ERR_N; r_warn = WARN_N; r_ok = CRC_OK;
            r_crc_in = CRC_IN;
         end
         if (TIMEOUT_ERR) begin r_tmo++; r_tmo_at = n; end
         if (r_dv > 0 && !MA) r_ma_low_post++;
         if (ma_prev && !MA) begin
            if (r_fall1 < 0) r_fall1 = n; else if (r_fall2 < 0) r_fall2 = n;
         end
         if (!ma_prev && MA && r_rise1 < 0) r_rise1 = n;
         if (rst_at >= 0 && r_strb == rst_at) begin RST = 1'b1; break; end
         if (!BUSY) begin r_busy_fall_at = n; break; end
         if (ma_prev && !MA && idx < len) begin
            SLO = bits[len-1-idx]; idx++;
         end else if (!ma_prev && MA && len > 0 && idx == len && !tmo_on) begin
            SLO = 1'b0; tmo_on = 1;
         end
         if (tmo_on) begin
            tmo_cnt++;
            if (tmo_cnt == 60) begin SLO = 1'b1; r_rel_at = n; end
         end
         ma_prev = MA;
      end
      START = 1'b0;
      SLO   = 1'b1;
   endtask

   task automatic test_reset;
      RST = 1'b1; START = 1'b0; SLO = 1'b1;
      repeat (3) @(negedge CLK);
      n_tests++; if (MA !== 1'b1) begin n_fail++; $display("FAIL rst_ma: got %b want 1", MA); end
      n_tests++; if ({BUSY, CRC_CLEAR, BIT_STRB, BIT_VAL, DATA_VALID, TIMEOUT_ERR} !== 6'b0) begin
         n_fail++; $display("FAIL rst_ctrl: got %b want 000000",
                            {BUSY, CRC_CLEAR, BIT_STRB, BIT_VAL, DATA_VALID, TIMEOUT_ERR}); end
      n_tests++; if ({POS_DATA, ERR_N, WARN_N, CRC_OK} !== '0) begin
         n_fail++; $display("FAIL rst_fields: got %h %b%b%b want 0", POS_DATA, ERR_N, WARN_N, CRC_OK); end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_nominal;
      run_frame(mk_frame(32'd0, 1'b1, 1'b1, 6'b111010), 38, -1, 1'b1);
      n_tests++; if (r_clr !== 1 || r_clr_at !== 0) begin n_fail++;
         $display("FAIL nom_crc_clear: got count %0d at %0d want 1 at 0", r_clr, r_clr_at); end
      n_tests++; if (r_strb !== 28) begin n_fail++; $display("FAIL nom_strobes: got %0d want 28", r_strb); end
      n_tests++; if (r_strb_bits[27:0] !== 28'h0000003) begin n_fail++;
         $display("FAIL nom_strobe_bits: got %h want 0000003", r_strb_bits[27:0]); end
      n_tests++; if (r_dv !== 1) begin n_fail++; $display("FAIL nom_dv_count: got %0d want 1", r_dv); end
      n_tests++; if (r_crc_in !== 6'h05) begin n_fail++; $display("FAIL nom_crc_in: got %h want 05", r_crc_in); end
      n_tests++; if ({r_pos, r_err, r_warn, r_ok} !== {26'd0, 3'b111}) begin n_fail++;
         $display("FAIL nom_fields: got %h %b%b%b want 0 111", r_pos, r_err, r_warn, r_ok); end
      n_tests++; if (r_fall1 !== 25 || r_rise1 !== 50 || r_fall2 !== 75) begin n_fail++;
         $display("FAIL ma_timing: got fall %0d rise %0d fall %0d want 25 50 75", r_fall1, r_rise1, r_fall2); end
      n_tests++; if (r_ma_low_post !== 0) begin n_fail++;
         $display("FAIL ma_high_after_crc: got %0d low cycles want 0", r_ma_low_post); end
      n_tests++; if (r_tmo !== 0) begin n_fail++; $display("FAIL nom_timeout: got %0d want 0", r_tmo); end
      n_tests++; if (r_rel_at < 0 || r_busy_fall_at !== r_rel_at + 3) begin n_fail++;
         $display("FAIL nom_busy_fall: got %0d want release %0d + 3", r_busy_fall_at, r_rel_at); end
      repeat (10) @(negedge CLK);
      n_tests++; if (MA !== 1'b1 || BUSY !== 1'b0) begin n_fail++;
         $display("FAIL nom_idle: got MA %b BUSY %b want 1 0", MA, BUSY); end
   endtask

   task automatic test_crc_error;
      run_frame(mk_frame(32'd0, 1'b1, 1'b1, 6'b111011), 38, -1, 1'b0);
      n_tests++; if (r_dv !== 1) begin n_fail++; $display("FAIL crcerr_dv_count: got %0d want 1", r_dv); end
      n_tests++; if (r_ok !== 1'b0) begin n_fail++; $display("FAIL crcerr_ok: got %b want 0", r_ok); end
      n_tests++; if ({r_pos, r_err, r_warn} !== {26'd0, 2'b11}) begin n_fail++;
         $display("FAIL crcerr_fields: got %h %b%b want 0 11", r_pos, r_err, r_warn); end
      repeat (5) @(negedge CLK);
   endtask

   task automatic test_err_warn;
      run_frame(mk_frame(32'd0, 1'b0, 1'b0, 6'b111111), 38, -1, 1'b0);
      n_tests++; if (r_dv !== 1) begin n_fail++; $display("FAIL ew_dv_count: got %0d want 1", r_dv); end
      n_tests++; if ({r_err, r_warn, r_ok} !== 3'b001) begin n_fail++;
         $display("FAIL ew_fields: got %b%b%b want 001", r_err, r_warn, r_ok); end
      n_tests++; if (ERR_N !== 1'b0 || WARN_N !== 1'b0) begin n_fail++;
         $display("FAIL ew_hold: got %b%b want 00", ERR_N, WARN_N); end
      repeat (5) @(negedge CLK);
   endtask

   task automatic test_data_pattern;
      logic [63:0] body;
      logic [5:0]  line;
      body = {36'd0, 26'h2D5C3A9, 2'b10};
      line = ~crc6(body, 28);
      run_frame(mk_frame(32'h02D5C3A9, 1'b1, 1'b0, line), 38, -1, 1'b0);
      n_tests++; if (r_pos !== 26'h2D5C3A9) begin n_fail++;
         $display("FAIL pat_pos: got %h want 2d5c3a9", r_pos); end
      n_tests++; if ({r_err, r_warn, r_ok} !== 3'b101) begin n_fail++;
         $display("FAIL pat_flags: got %b%b%b want 101", r_err, r_warn, r_ok); end
      n_tests++; if (r_strb_bits[27:0] !== body[27:0]) begin n_fail++;
         $display("FAIL pat_strobe_bits: got %h want %h", r_strb_bits[27:0], body[27:0]); end
      repeat (5) @(negedge CLK);
   endtask

   task automatic test_timeout;
      run_frame(64'd0, 0, -1, 1'b0);
      n_tests++; if (r_tmo !== 1 || r_tmo_at !== 4000) begin n_fail++;
         $display("FAIL tmo_pulse: got %0d at %0d want 1 at 4000", r_tmo, r_tmo_at); end
      n_tests++; if (r_dv !== 0 || r_strb !== 0) begin n_fail++;
         $display("FAIL tmo_no_data: got dv %0d strb %0d want 0 0", r_dv, r_strb); end
      n_tests++; if (r_busy_fall_at !== 4001 || MA !== 1'b1) begin n_fail++;
         $display("FAIL tmo_idle: got busy fall %0d MA %b want 4001 1", r_busy_fall_at, MA); end
      n_tests++; if (POS_DATA !== 26'h2D5C3A9 || WARN_N !== 1'b0) begin n_fail++;
         $display("FAIL tmo_hold: got %h %b want 2d5c3a9 0", POS_DATA, WARN_N); end
      repeat (5) @(negedge CLK);
   endtask

   task automatic test_reset_mid_frame;
      int dv;
      run_frame(mk_frame(32'h0155AA55, 1'b1, 1'b1, 6'b000000), 38, 10, 1'b0);
      @(negedge CLK); RST = 1'b0;
      n_tests++; if (r_strb !== 10) begin n_fail++; $display("FAIL rmid_reach: got %0d strobes want 10", r_strb); end
      n_tests++; if (MA !== 1'b1 || BUSY !== 1'b0 || BIT_STRB !== 1'b0) begin n_fail++;
         $display("FAIL rmid_ctrl: got MA %b BUSY %b STRB %b want 1 0 0", MA, BUSY, BIT_STRB); end
      n_tests++; if ({POS_DATA, ERR_N, WARN_N, CRC_OK} !== '0) begin n_fail++;
         $display("FAIL rmid_fields: got %h %b%b%b want 0", POS_DATA, ERR_N, WARN_N, CRC_OK); end
      dv = 0;
      for (int i = 0; i < 300; i++) begin @(negedge CLK); if (DATA_VALID) dv++; end
      n_tests++; if (dv !== 0 || BUSY !== 1'b0) begin n_fail++;
         $display("FAIL rmid_quiet: got dv %0d BUSY %b want 0 0", dv, BUSY); end
      run_frame(mk_frame(32'd0, 1'b1, 1'b1, 6'b111010), 38, -1, 1'b0);
      n_tests++; if (r_clr !== 1 || r_clr_at !== 0 || r_strb !== 28) begin n_fail++;
         $display("FAIL rmid_restart: got clr %0d at %0d strb %0d want 1 0 28", r_clr, r_clr_at, r_strb); end
      n_tests++; if (r_dv !== 1 || r_ok !== 1'b1 || r_pos !== 26'd0) begin n_fail++;
         $display("FAIL rmid_frame: got dv %0d ok %b pos %h want 1 1 0", r_dv, r_ok, r_pos); end
      repeat (5) @(negedge CLK);
   endtask

   task automatic test_start_rst;
      @(negedge CLK); START = 1'b1; RST = 1'b1;
      @(negedge CLK);
      n_tests++; if (BUSY !== 1'b0 || CRC_CLEAR !== 1'b0 || MA !== 1'b1) begin n_fail++;
         $display("FAIL start_rst: got BUSY %b CLR %b MA %b want 0 0 1", BUSY, CRC_CLEAR, MA); end
      START = 1'b0; RST = 1'b0;
      repeat (30) @(negedge CLK);
      n_tests++; if (BUSY !== 1'b0 || MA !== 1'b1) begin n_fail++;
         $display("FAIL start_rst_after: got BUSY %b MA %b want 0 1", BUSY, MA); end
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; SLO = 1'b1;
      test_reset;
      test_nominal;
      test_crc_error;
      test_err_warn;
      test_data_pattern;
      test_timeout;
      test_reset_mid_frame;
      test_start_rst;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/biss_c_frame_rx.md
Name: biss_c_frame_rx

Overview:
- BiSS-C master frame engine.
- Generates the MA clock and samples SLO from a single-cycle absolute encoder.
- Parses Ack, Start, CDS, position, nE, nW and CRC.
- Streams the CRC-covered bits into the downstream 6-bit CRC unit (poly x^6+x+1, init 0) and compares that unit's result against the received, inverted CRC.
- Sits between the encoder line transceivers and the position/status register bank.

Parameters:
CLK_DIV, 25, CLK cycles per MA half-period (>=4); 50 MHz CLK gives 1 MHz MA.
DATA_BITS, 26, position field width, 8..32.
TIMEOUT_CYCLES, 4000, CLK-cycle watchdog for the ACK/START phases and for the line-idle wait.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
START  in  1  frame request pulse; ignored unless BUSY=0
SLO  in  1  encoder data line, asynchronous; 2-flop synchronised internally
MA  out  1  encoder clock; idles high
CRC_CLEAR  out  1  one-cycle clear pulse to the CRC unit
BIT_VAL  out  1  bit value to the CRC unit
BIT_STRB  out  1  one-cycle strobe to the CRC unit; the unit acts on its rising edge
CRC_IN  in  6  current CRC value from the CRC unit
POS_DATA  out  DATA_BITS  last received position, MSB first on the line
ERR_N  out  1  last received nE bit
WARN_N  out  1  last received nW bit
CRC_OK  out  1  last frame CRC matched
DATA_VALID  out  1  one-cycle pulse when the output fields update
TIMEOUT_ERR  out  1  one-cycle pulse on watchdog abort
BUSY  out  1  frame in progress

Behaviour:
- Reset: MA=1, BUSY=0, CRC_CLEAR=0, BIT_STRB=0, BIT_VAL=0, POS_DATA=0, ERR_N=0, WARN_N=0, CRC_OK=0, DATA_VALID=0, TIMEOUT_ERR=0, state=IDLE, all counters 0.
- Reset mid-frame: abort at once; MA high on the next edge; no DATA_VALID for the aborted frame.
- MA generation:
  - Divider counts 0..CLK_DIV-1; MA toggles at terminal count, while MA runs only.
  - The first edge is a falling edge exactly CLK_DIV cycles after START is accepted.
  - sample_tick = the cycle MA goes 0->1; SLO_sync is sampled only on sample_tick.
  - Line-delay compensation is out of scope.
- States:
  - IDLE: on START, assert CRC_CLEAR for 1 cycle, set BUSY=1, start MA, go to WAIT_ACK.
  - WAIT_ACK: on a tick with SLO=0, go to WAIT_START.
  - WAIT_START: on a tick with SLO=1, go to CDS.
  - CDS: consume 1 tick; value discarded, not sent to CRC.
  - DATA: DATA_BITS ticks, shifted MSB first.
  - ERRW: 2 ticks, nE then nW.
  - CRC: 6 ticks, MSB first.
  - CHECK: MA held high, divider stopped; wait 3 cycles, then latch outputs and pulse DATA_VALID. CRC_OK = (CRC_IN == ~crc_rx).
  - WAIT_IDLE: wait for SLO_sync=1 (end of encoder timeout), then BUSY=0 and go to IDLE.
- CRC feed:
  - In DATA and ERRW, each sample_tick drives BIT_VAL=sampled bit with BIT_STRB=1 for exactly that cycle.
  - BIT_STRB is low at all other times.
  - CDS and CRC-field bits are never strobed.
- Output fields hold their values between frames; only DATA_VALID updates them.
- Watchdog:
  - Counter clears on entry to WAIT_ACK and WAIT_IDLE.
  - If it reaches TIMEOUT_CYCLES while in WAIT_ACK, WAIT_START or WAIT_IDLE: pulse TIMEOUT_ERR, force MA=1, no DATA_VALID.
  - Then go to WAIT_IDLE, with its own fresh timeout.
  - A second expiry in WAIT_IDLE forces IDLE with BUSY=0.
- START while BUSY=1 is ignored; no queueing.
- START and RST in the same cycle: RST wins.
- Bit counters are sized for DATA_BITS max 32 and never wrap inside a frame.

Test Plan:
- Nominal frame: CLK_DIV=25, DATA_BITS=26, slave sends Ack, Start, CDS=0, data=0, nE=1, nW=1, CRC line 111010 -> exactly 28 BIT_STRB pulses; CRC_IN=6'h05; DATA_VALID once with POS_DATA=0, ERR_N=1, WARN_N=1, CRC_OK=1; BUSY falls after SLO returns high.
- CRC error: same frame with CRC line 111011 -> CRC_OK=0; POS_DATA still updated; DATA_VALID pulses once.
- Error/warning active: data=0, nE=0, nW=0, CRC line 111111 -> CRC_OK=1, ERR_N=0, WARN_N=0.
- MA timing: START accepted -> first MA fall 25 cycles later; MA period 50 cycles; MA=1 throughout IDLE and after the CRC field.
- No encoder: SLO stuck high -> TIMEOUT_ERR pulses at 4000 cycles; MA=1; no DATA_VALID; BUSY=0 after the WAIT_IDLE resolves.
- RST asserted at DATA bit 10 -> next cycle MA=1, BUSY=0, outputs zero; a subsequent START runs a clean frame with CRC_CLEAR pulsed.
